vote_session_ctrl: RTL and testbench
====================================

VOTE_SESSION_CTRL -- requirements
Module: vote_session_ctrl

Interface
REQ-001 Parameter N_VOTERS, default 11, number of eligible voters (1..15).
REQ-002 Parameter THRESHOLD, default 6, minimum yes votes for the motion to pass.
REQ-003 Parameter TIMEOUT, default 1000, number of cycles the ballot window stays open (>=1).
REQ-004 Port clk, input, 1, the single clock; all state updates on rising edge.
REQ-005 Port rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port start, input, 1, request to open a new session; honoured only in IDLE.
REQ-007 Port abort, input, 1, cancels an open session.
REQ-008 Port vote_valid, input, 1, a ballot is presented this cycle.
REQ-009 Port vote_id, input, 4, voter index 0..N_VOTERS-1.
REQ-010 Port vote_val, input, 1, 1 = yes, 0 = no.
REQ-011 Port vote_ready, output, 1, ballot window open; a ballot is taken when vote_valid and vote_ready are both 1.
REQ-012 Port vote_err, output, 1, one-cycle pulse when a taken ballot is rejected.
REQ-013 Port ack, input, 1, consumer acknowledges the result.
REQ-014 Port busy, output, 1, high in every state except IDLE.
REQ-015 Port done, output, 1, result valid; held until ack.
REQ-016 Port decision, output, 1, 1 = passed; valid while done=1.
REQ-017 Port yes_count, output, 4, accepted yes ballots this session.
REQ-018 Port no_count, output, 4, accepted no ballots this session.
REQ-019 Port aborted, output, 1, one-cycle pulse when a session is cancelled.

Function
REQ-020 The FSM SHALL have the states IDLE, OPEN, CLOSE and RESULT.
REQ-021 In IDLE, start=1 SHALL move to OPEN on the next edge, clear the voted mask, clear both counts, and load the timer with TIMEOUT.
REQ-022 vote_ready SHALL be 1 only in OPEN, for exactly TIMEOUT cycles unless the session closes early or is aborted.
REQ-023 A taken ballot SHALL be rejected if vote_id >= N_VOTERS or the voter's mask bit is set; on rejection, vote_err=1 on the next cycle and the counts and mask are unchanged.
REQ-024 An accepted ballot SHALL set the voter's mask bit and increment yes_count or no_count by 1, visible the next cycle.
REQ-025 At most one ballot SHALL be taken per cycle; counts saturate only by construction (max N_VOTERS) and never wrap.
REQ-026 In OPEN the timer SHALL decrement every cycle; on the cycle the timer equals 1, any ballot is still taken and the FSM moves to CLOSE.
REQ-027 When an accepted ballot completes the mask (all N_VOTERS voted), the FSM SHALL move to CLOSE on the next edge regardless of the timer.
REQ-028 CLOSE SHALL last one cycle and register decision = (yes_count >= THRESHOLD), then move to RESULT.
REQ-029 Latency from the last accepted ballot to done=1 SHALL be 2 cycles.
REQ-030 In RESULT, done=1 and decision and the counts SHALL be held stable until ack=1, which returns the FSM to IDLE; done falls on the same edge.
REQ-031 abort=1 in OPEN or CLOSE SHALL return the FSM to IDLE, pulse aborted, and discard any same-cycle ballot (abort wins); abort is ignored in IDLE and RESULT.
REQ-032 start SHALL be ignored outside IDLE; ack SHALL be ignored outside RESULT.
REQ-033 yes_count and no_count SHALL retain their last values in IDLE until the next start.

Reset
REQ-034 rst_n=0 SHALL immediately force IDLE, with vote_ready, vote_err, busy, done, decision, aborted, yes_count, no_count and the mask all 0.
REQ-035 Reset asserted mid-session SHALL discard all tallies with no done or aborted pulse.

Verification
REQ-036 Bench: start; voters 0-5 yes, 6-10 no on consecutive cycles -> CLOSE after voter 10, done=1 two cycles after the last ballot, decision=1, yes_count=6, no_count=5.
REQ-037 Bench: TIMEOUT=20; 5 yes ballots only -> vote_ready high exactly 20 cycles, then decision=0, yes_count=5, no_count=0.
REQ-038 Bench: voter 3 votes yes, then voter 3 votes no, then vote_id=12 -> two vote_err pulses; yes_count=1, no_count=0.
REQ-039 Bench: abort in the same cycle as a valid ballot -> aborted pulse, counts unchanged, back to IDLE, done never asserted.
REQ-040 Bench: ballot on the final window cycle (timer=1) -> counted; ack held low 10 cycles -> done and decision stable; start during RESULT -> ignored.
REQ-041 Bench: rst_n pulled low mid-OPEN with 4 votes recorded -> all outputs 0 asynchronously; a new start yields fresh counts of 0.

Source files
------------

// File: rtl/vote_session_ctrl.sv
// vote_session_ctrl: ballot session controller.
// Opens a timed ballot window on start and accepts at most one ballot per
// cycle. Duplicate and out-of-range voters are rejected. The window closes
// when every voter has voted or the timer runs out. The pass/fail decision
// is then held until the consumer acknowledges it.
module vote_session_ctrl #(
    parameter int N_VOTERS  = 11,
    parameter int THRESHOLD = 6,
    parameter int TIMEOUT   = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       vote_valid,
    input  logic [3:0] vote_id,
    input  logic       vote_val,
    output logic       vote_ready,
    output logic       vote_err,
    input  logic       ack,
    output logic       busy,
    output logic       done,
    output logic       decision,
    output logic [3:0] yes_count,
    output logic [3:0] no_count,
    output logic       aborted
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT);
    localparam logic [4:0] NV5 = 5'(N_VOTERS);
    localparam logic [4:0] TH5 = 5'(THRESHOLD);
    localparam logic [N_VOTERS-1:0] FULL_MASK = {N_VOTERS{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_OPEN   = 2'd1,
        S_CLOSE  = 2'd2,
        S_RESULT = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [TW-1:0]         r_timer;
    logic [N_VOTERS-1:0]   r_mask;
    logic [3:0]            r_yes;
    logic [3:0]            r_no;
    logic                  r_err;
    logic                  r_aborted;
    logic                  r_decision;

    logic [N_VOTERS-1:0]   w_onehot;
    logic                  w_in_range;
    logic                  w_dup;
    logic                  w_take;
    logic                  w_accept;
    logic                  w_reject;
    logic                  w_completes;
    logic                  w_abort_hit;

    // Decode the presented ballot into take/accept/reject qualifiers.
    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < N_VOTERS; i++) begin
            w_onehot[i] = (vote_id == 4'(i));
        end
        w_in_range  = ({1'b0, vote_id} < NV5);
        w_dup       = |(r_mask & w_onehot);
        w_abort_hit = abort && ((r_state == S_OPEN) || (r_state == S_CLOSE));
        // Abort wins over any same-cycle ballot, so it is not even taken.
        w_take      = (r_state == S_OPEN) && vote_valid && !abort;
        w_reject    = w_take && (!w_in_range || w_dup);
        w_accept    = w_take && w_in_range && !w_dup;
        w_completes = ((r_mask | w_onehot) == FULL_MASK);
    end

    // Next-state selection for the session FSM.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_OPEN;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_OPEN: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else if (w_accept && w_completes) begin
                    w_next = S_CLOSE;
                end else if (r_timer == TW'(1)) begin
                    w_next = S_CLOSE;
                end else begin
                    w_next = S_OPEN;
                end
            end
            S_CLOSE: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_RESULT;
                end
            end
            S_RESULT: begin
                if (ack) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_RESULT;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Session state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Tally, mask, timer, decision and the one-cycle status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer    <= '0;
            r_mask     <= '0;
            r_yes      <= 4'd0;
            r_no       <= 4'd0;
            r_err      <= 1'b0;
            r_aborted  <= 1'b0;
            r_decision <= 1'b0;
        end else begin
            r_err     <= w_reject;
            r_aborted <= w_abort_hit;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_timer    <= TIMER_LOAD;
                        r_mask     <= '0;
                        r_yes      <= 4'd0;
                        r_no       <= 4'd0;
                        r_decision <= 1'b0;
                    end
                end
                S_OPEN: begin
                    if (r_timer != TW'(0)) begin
                        r_timer <= r_timer - TW'(1);
                    end
                    if (w_accept) begin
                        r_mask <= r_mask | w_onehot;
                        if (vote_val) begin
                            r_yes <= r_yes + 4'd1;
                        end else begin
                            r_no <= r_no + 4'd1;
                        end
                    end
                end
                S_CLOSE: begin
                    if (!abort) begin
                        r_decision <= ({1'b0, r_yes} >= TH5);
                    end
                end
                default: begin
                    r_decision <= r_decision;
                end
            endcase
        end
    end

    assign vote_ready = (r_state == S_OPEN);
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_RESULT);
    assign vote_err   = r_err;
    assign aborted    = r_aborted;
    assign decision   = r_decision;
    assign yes_count  = r_yes;
    assign no_count   = r_no;

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Directed testbench for vote_session_ctrl (N_VOTERS=11, THRESHOLD=6, TIMEOUT=20).
module tb_vote_session_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       vote_valid;
    logic [3:0] vote_id;
    logic       vote_val;
    logic       vote_ready;
    logic       vote_err;
    logic       ack;
    logic       busy;
    logic       done;
    logic       decision;
    logic [3:0] yes_count;
    logic [3:0] no_count;
    logic       aborted;

    int total = 0;
    int bad   = 0;

    vote_session_ctrl #(
        .N_VOTERS (11),
        .THRESHOLD(6),
        .TIMEOUT  (20)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .vote_valid(vote_valid),
        .vote_id   (vote_id),
        .vote_val  (vote_val),
        .vote_ready(vote_ready),
        .vote_err  (vote_err),
        .ack       (ack),
        .busy      (busy),
        .done      (done),
        .decision  (decision),
        .yes_count (yes_count),
        .no_count  (no_count),
        .aborted   (aborted)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vote(input logic [3:0] id, input logic val);
        vote_valid = 1'b1;
        vote_id    = id;
        vote_val   = val;
        tick();
        vote_valid = 1'b0;
    endtask

    // Directed sequence.
    initial begin
        int cnt;
        int k;
        logic dec_ok;
        logic done_ok;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; ack = 1'b0;
        vote_valid = 1'b0; vote_id = 4'd0; vote_val = 1'b0;
        #12;
        chk("rst_ready",  32'(vote_ready), 32'd0);
        chk("rst_busy",   32'(busy),       32'd0);
        chk("rst_done",   32'(done),       32'd0);
        chk("rst_dec",    32'(decision),   32'd0);
        chk("rst_counts", {24'd0, yes_count, no_count}, 32'd0);
        chk("rst_pulses", {30'd0, vote_err, aborted}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Full electorate: 0-5 yes, 6-10 no.
        start = 1'b1; tick(); start = 1'b0;
        chk("t1_open_ready", 32'(vote_ready), 32'd1);
        chk("t1_open_busy",  32'(busy),       32'd1);
        for (int i = 0; i < 11; i++) begin
            vote(4'(i), (i < 6) ? 1'b1 : 1'b0);
        end
        chk("t1_close_ready", 32'(vote_ready), 32'd0);
        chk("t1_close_done",  32'(done),       32'd0);
        chk("t1_close_busy",  32'(busy),       32'd1);
        tick();
        chk("t1_done", 32'(done),      32'd1);
        chk("t1_dec",  32'(decision),  32'd1);
        chk("t1_yes",  32'(yes_count), 32'd6);
        chk("t1_no",   32'(no_count),  32'd5);
        ack = 1'b1; tick(); ack = 1'b0;
        chk("t1_ack_done",  32'(done), 32'd0);
        chk("t1_ack_busy",  32'(busy), 32'd0);
        chk("t1_idle_keep", {24'd0, yes_count, no_count}, {24'd0, 4'd6, 4'd5});

        // Timeout with five yes ballots.
        start = 1'b1; tick(); start = 1'b0;
        chk("t2_clear", {24'd0, yes_count, no_count}, 32'd0);
        cnt = 0; k = 0;
        while (vote_ready && k < 40) begin
            cnt++;
            vote_valid = (k < 5);
            vote_id    = 4'(k);
            vote_val   = 1'b1;
            tick();
            k++;
        end
        vote_valid = 1'b0;
        chk("t2_window_len", 32'(cnt), 32'd20);
        chk("t2_close_busy", 32'(busy), 32'd1);
        tick();
        chk("t2_done", 32'(done),      32'd1);
        chk("t2_dec",  32'(decision),  32'd0);
        chk("t2_yes",  32'(yes_count), 32'd5);
        chk("t2_no",   32'(no_count),  32'd0);
        ack = 1'b1; tick(); ack = 1'b0;

        // Duplicate and out-of-range ballots.
        start = 1'b1; tick(); start = 1'b0;
        vote(4'd3, 1'b1);
        chk("t3_first_err", 32'(vote_err),  32'd0);
        chk("t3_first_yes", 32'(yes_count), 32'd1);
        vote(4'd3, 1'b0);
        chk("t3_dup_err",    32'(vote_err), 32'd1);
        chk("t3_dup_counts", {24'd0, yes_count, no_count}, {24'd0, 4'd1, 4'd0});
        vote(4'd12, 1'b1);
        chk("t3_range_err",    32'(vote_err), 32'd1);
        chk("t3_range_counts", {24'd0, yes_count, no_count}, {24'd0, 4'd1, 4'd0});
        tick();
        chk("t3_err_clear", 32'(vote_err), 32'd0);

        // Abort with a same-cycle ballot (session still open from above).
        abort = 1'b1; vote_valid = 1'b1; vote_id = 4'd5; vote_val = 1'b1;
        tick();
        abort = 1'b0; vote_valid = 1'b0;
        chk("t4_aborted", 32'(aborted), 32'd1);
        chk("t4_busy",    32'(busy),    32'd0);
        chk("t4_ready",   32'(vote_ready), 32'd0);
        chk("t4_counts",  {24'd0, yes_count, no_count}, {24'd0, 4'd1, 4'd0});
        done_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) abort = 1'b1;
            if (done) done_ok = 1'b0;
            tick();
            abort = 1'b0;
        end
        chk("t4_no_done",      32'(done_ok), 32'd1);
        chk("t4_idle_abort",   32'(aborted), 32'd0);

        // Ballot on the final window cycle, long ack wait, start ignored.
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 19; i++) tick();
        chk("t5_last_ready", 32'(vote_ready), 32'd1);
        vote(4'd7, 1'b1);
        chk("t5_closed", 32'(vote_ready), 32'd0);
        chk("t5_yes",    32'(yes_count),  32'd1);
        tick();
        chk("t5_done", 32'(done), 32'd1);
        dec_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!done || decision || yes_count != 4'd1 || no_count != 4'd0) dec_ok = 1'b0;
            start = (i == 4);
            tick();
        end
        start = 1'b0;
        chk("t5_stable",       32'(dec_ok), 32'd1);
        chk("t5_start_ignore", 32'(done),   32'd1);
        chk("t5_ready_off",    32'(vote_ready), 32'd0);
        ack = 1'b1; tick(); ack = 1'b0;
        chk("t5_ack", 32'(done), 32'd0);

        // Asynchronous reset mid-session.
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 4; i++) vote(4'(i), 1'b1);
        chk("t6_four", 32'(yes_count), 32'd4);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_rst_state", {28'd0, vote_ready, busy, done, decision}, 32'd0);
        chk("t6_rst_counts", {24'd0, yes_count, no_count}, 32'd0);
        chk("t6_rst_pulses", {30'd0, vote_err, aborted}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        chk("t6_fresh", {24'd0, yes_count, no_count}, 32'd0);
        chk("t6_ready", 32'(vote_ready), 32'd1);
        vote(4'd0, 1'b1);
        chk("t6_revote_err", 32'(vote_err),  32'd0);
        chk("t6_revote_yes", 32'(yes_count), 32'd1);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("t6_abort", 32'(aborted), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
